// File: rtl/timer_pwm_if.sv
// rtl/timer_pwm_if.sv - config and status bundle between the MCU peripheral regs and timer_pwm
interface timer_pwm_if #(
  parameter int WIDTH       = 16,
  parameter int PRESC_WIDTH = 8,
  parameter int NUM_CH      = 2
);
  logic                      en_i;
  logic                      mode_i;
  logic                      start_i;
  logic [PRESC_WIDTH-1:0]    presc_i;
  logic [WIDTH-1:0]          period_i;
  logic [NUM_CH*WIDTH-1:0]   cmp_i;
  logic                      irq_clr_i;
  logic [WIDTH-1:0]          cnt_o;
  logic [NUM_CH-1:0]         pwm_o;
  logic                      ovf_o;
  logic                      irq_o;
  logic                      running_o;

  modport master (
    output en_i, mode_i, start_i, presc_i, period_i, cmp_i, irq_clr_i,
    input  cnt_o, pwm_o, ovf_o, irq_o, running_o
  );

  modport slave (
    input  en_i, mode_i, start_i, presc_i, period_i, cmp_i, irq_clr_i,
    output cnt_o, pwm_o, ovf_o, irq_o, running_o
  );
endinterface

// File: rtl/timer_pwm.sv
// rtl/timer_pwm.sv - prescaled up-counter with periodic/one-shot modes, compare PWM channels and sticky overflow irq
module timer_pwm #(
  parameter int WIDTH       = 16,
  parameter int PRESC_WIDTH = 8,
  parameter int NUM_CH      = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  timer_pwm_if.slave bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]              state, state_next;
  logic [WIDTH-1:0]        cnt, cnt_next;
  logic [PRESC_WIDTH-1:0]  psc, psc_next;
  logic [WIDTH-1:0]        period_sh, period_next;
  logic [PRESC_WIDTH-1:0]  presc_sh, presc_next;
  logic [NUM_CH*WIDTH-1:0] cmp_sh, cmp_next;
  logic [NUM_CH-1:0]       pwm, pwm_next;
  logic                    ovf, irq, irq_next;
  logic                    run, tick, wrap, reload;

  always_comb begin
    run    = (state == ST_RUN);
    tick   = run && bus.en_i && (psc >= presc_sh);
    wrap   = tick && (cnt >= period_sh);
    // shadows follow the inputs while idle and latch fresh values only at a wrap
    reload = !run || wrap;

    state_next = state;
    case (state)
      ST_IDLE: if (bus.en_i && (!bus.mode_i || bus.start_i)) state_next = ST_RUN;
      ST_RUN: begin
        if (!bus.en_i)                state_next = ST_IDLE;
        else if (wrap && bus.mode_i)  state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    cnt_next = cnt;
    psc_next = psc;
    if (!run || !bus.en_i) begin
      cnt_next = '0;
      psc_next = '0;
    end else if (tick) begin
      psc_next = '0;
      cnt_next = wrap ? '0 : cnt + 1'b1;
    end else begin
      psc_next = psc + 1'b1;
    end

    period_next = reload ? bus.period_i : period_sh;
    presc_next  = reload ? bus.presc_i  : presc_sh;
    cmp_next    = reload ? bus.cmp_i    : cmp_sh;

    // compare against the shadow that will be live next cycle so pwm lines up with cnt_o
    pwm_next = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      pwm_next[k] = (state_next == ST_RUN) && (cnt_next < cmp_next[k*WIDTH +: WIDTH]);
    end

    irq_next = wrap || (irq && !bus.irq_clr_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      psc       <= '0;
      period_sh <= '0;
      presc_sh  <= '0;
      cmp_sh    <= '0;
      pwm       <= '0;
      ovf       <= 1'b0;
      irq       <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      psc       <= psc_next;
      period_sh <= period_next;
      presc_sh  <= presc_next;
      cmp_sh    <= cmp_next;
      pwm       <= pwm_next;
      ovf       <= wrap;
      irq       <= irq_next;
    end
  end

  assign bus.cnt_o     = cnt;
  assign bus.pwm_o     = pwm;
  assign bus.ovf_o     = ovf;
  assign bus.irq_o     = irq;
  assign bus.running_o = (state == ST_RUN);

endmodule

// File: tb/tb_timer_pwm.sv
// tb/tb_timer_pwm.sv - randomized and directed bench for timer_pwm against a behavioural model
module tb_timer_pwm;
  localparam int WIDTH       = 16;
  localparam int PRESC_WIDTH = 8;
  localparam int NUM_CH      = 2;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  timer_pwm_if #(.WIDTH(WIDTH), .PRESC_WIDTH(PRESC_WIDTH), .NUM_CH(NUM_CH)) bus ();

  timer_pwm #(.WIDTH(WIDTH), .PRESC_WIDTH(PRESC_WIDTH), .NUM_CH(NUM_CH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model state
  bit          m_run;
  int unsigned m_cnt, m_psc, m_per, m_presc;
  int unsigned m_cmp [NUM_CH];
  bit          m_ovf, m_irq;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic load_shadows();
    m_per   = bus.period_i;
    m_presc = bus.presc_i;
    for (int k = 0; k < NUM_CH; k++) m_cmp[k] = bus.cmp_i[k*WIDTH +: WIDTH];
  endtask

  task automatic model_reset();
    m_run = 0; m_cnt = 0; m_psc = 0; m_per = 0; m_presc = 0;
    for (int k = 0; k < NUM_CH; k++) m_cmp[k] = 0;
    m_ovf = 0; m_irq = 0;
  endtask

  task automatic model_step();
    m_ovf = 0;
    if (!m_run) begin
      load_shadows();
      if (bus.en_i && (!bus.mode_i || bus.start_i)) m_run = 1;
    end else if (!bus.en_i) begin
      m_run = 0; m_cnt = 0; m_psc = 0;
    end else if (m_psc >= m_presc) begin
      m_psc = 0;
      if (m_cnt >= m_per) begin
        m_cnt = 0;
        m_ovf = 1;
        load_shadows();
        if (bus.mode_i) m_run = 0;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end else begin
      m_psc = m_psc + 1;
    end
    if (bus.irq_clr_i) m_irq = 0;
    if (m_ovf) m_irq = 1;
  endtask

  task automatic compare_all();
    logic [NUM_CH-1:0] exp_pwm;
    for (int k = 0; k < NUM_CH; k++) exp_pwm[k] = m_run && (m_cnt < m_cmp[k]);
    check("cnt",     32'(bus.cnt_o),     m_cnt);
    check("pwm",     32'(bus.pwm_o),     32'(exp_pwm));
    check("ovf",     32'(bus.ovf_o),     32'(m_ovf));
    check("irq",     32'(bus.irq_o),     32'(m_irq));
    check("running", 32'(bus.running_o), 32'(m_run));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    #1;
    compare_all();
  endtask

  task automatic set_cfg(input bit en, input bit mode, input int presc, input int period,
                         input int c0, input int c1);
    bus.en_i     = en;
    bus.mode_i   = mode;
    bus.presc_i  = PRESC_WIDTH'(presc);
    bus.period_i = WIDTH'(period);
    bus.cmp_i    = {WIDTH'(c1), WIDTH'(c0)};
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cnt"}, 32'(bus.cnt_o), 0);
    check({tag, "_pwm"}, 32'(bus.pwm_o), 0);
    check({tag, "_ovf"}, 32'(bus.ovf_o), 0);
    check({tag, "_irq"}, 32'(bus.irq_o), 0);
    check({tag, "_run"}, 32'(bus.running_o), 0);
  endtask

  initial begin
    rst = 1'b0;
    bus.start_i = 1'b0;
    bus.irq_clr_i = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0);

    // asynchronous reset before any clock edge
    #2 rst = 1'b1;
    #1 check_all_zero("rst_async");
    cycle();
    rst = 1'b0;
    model_reset();

    // periodic P=0 period=3, with irq clear colliding with a wrap
    set_cfg(1, 0, 0, 3, 2, 5);
    for (int n = 1; n <= 13; n++) begin
      bus.irq_clr_i = (n == 9 || n == 10);
      cycle();
      check("s1_cnt", 32'(bus.cnt_o), (n - 1) % 4);
      check("s1_ovf", 32'(bus.ovf_o), ((n - 1) % 4 == 0 && n > 1) ? 1 : 0);
      if (n == 9)  check("s1_irq_setwins", 32'(bus.irq_o), 1);
      if (n == 10) check("s1_irq_clr", 32'(bus.irq_o), 0);
    end
    bus.irq_clr_i = 1'b0;
    bus.en_i = 1'b0;
    cycle();

    // prescaler P=2 period=1
    set_cfg(1, 0, 2, 1, 1, 1);
    for (int n = 1; n <= 14; n++) begin
      cycle();
      check("s2_cnt", 32'(bus.cnt_o), ((n - 1) / 3) % 2);
      check("s2_ovf", 32'(bus.ovf_o), ((n - 1) % 6 == 0 && n > 1) ? 1 : 0);
    end
    bus.en_i = 1'b0;
    cycle();

    // one-shot period=4, run twice; start during RUN ignored
    set_cfg(1, 1, 0, 4, 2, 9);
    for (int r = 0; r < 2; r++) begin
      for (int n = 1; n <= 7; n++) begin
        bus.start_i = (n == 1 || n == 3);
        cycle();
        check("s3_cnt", 32'(bus.cnt_o), (n <= 5) ? n - 1 : 0);
        check("s3_run", 32'(bus.running_o), (n <= 5) ? 1 : 0);
        check("s3_ovf", 32'(bus.ovf_o), (n == 6) ? 1 : 0);
      end
    end
    bus.start_i = 1'b0;
    bus.en_i = 1'b0;
    cycle();

    // pwm duty with mid-period compare change, then disable mid-count
    set_cfg(1, 0, 0, 9, 3, 12);
    for (int n = 1; n <= 25; n++) begin
      if (n == 5) bus.cmp_i[WIDTH-1:0] = WIDTH'(7);
      cycle();
      check("s4_pwm", 32'(bus.pwm_o), {30'd0, 1'b1, ((n - 1) % 10) < ((n <= 10) ? 3 : 7)});
    end
    bus.en_i = 1'b0;
    cycle();
    check("s6_cnt", 32'(bus.cnt_o), 0);
    check("s6_run", 32'(bus.running_o), 0);
    check("s6_pwm", 32'(bus.pwm_o), 0);
    check("s6_ovf", 32'(bus.ovf_o), 0);

    // randomized segments
    for (int seg = 0; seg < 40; seg++) begin
      set_cfg(1, $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 9),
              $urandom_range(0, 12), $urandom_range(0, 12));
      for (int n = 0; n < int'($urandom_range(30, 80)); n++) begin
        bus.start_i   = ($urandom_range(0, 9) == 0);
        bus.irq_clr_i = ($urandom_range(0, 9) == 0);
        bus.en_i      = ($urandom_range(0, 29) != 0);
        if ($urandom_range(0, 19) == 0) bus.cmp_i[WIDTH-1:0] = WIDTH'($urandom_range(0, 12));
        if ($urandom_range(0, 19) == 0) bus.period_i = WIDTH'($urandom_range(0, 9));
        if ($urandom_range(0, 19) == 0) bus.presc_i = PRESC_WIDTH'($urandom_range(0, 3));
        cycle();
      end
    end
    bus.start_i = 1'b0;
    bus.irq_clr_i = 1'b0;

    // reset asserted between clock edges mid-count
    set_cfg(1, 0, 0, 9, 5, 5);
    for (int n = 0; n < 6; n++) cycle();
    #3 rst = 1'b1;
    #1 check_all_zero("rst_mid");
    cycle();
    rst = 1'b0;
    for (int n = 0; n < 6; n++) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
